// File: rtl/bcm_stdp_array.sv
// Triplet/pair STDP weight engine: one shared postsynaptic neuron, N_SYN presynaptic
// channels updated one per cycle after each time-step tick.
module bcm_stdp_array #(
    parameter int N_SYN    = 4,
    parameter int WIDTH    = 18,
    parameter int FRAC     = 16,
    parameter int T_PLUS   = 4,
    parameter int T_MINUS  = 5,
    parameter int T_Y      = 5,
    parameter int A3_PLUS  = 4,
    parameter int A2_MINUS = 7,
    parameter int W_INIT   = 0,
    parameter int W_MAX    = 1 << FRAC,
    parameter int W_MIN    = -(1 << FRAC),
    parameter int MODE     = 1,
    localparam int AW      = (N_SYN > 1) ? $clog2(N_SYN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic [N_SYN-1:0]        pre,
    input  logic                    post,
    input  logic                    learn_en,
    input  logic [AW-1:0]           rd_addr,
    output logic signed [WIDTH-1:0] rd_w,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun
);

    localparam logic signed [WIDTH-1:0] ONE_W    = WIDTH'(1 << FRAC);
    localparam logic signed [WIDTH-1:0] W_INIT_W = WIDTH'(W_INIT);
    localparam logic signed [WIDTH+1:0] W_MAX_X  = (WIDTH+2)'(W_MAX);
    localparam logic signed [WIDTH+1:0] W_MIN_X  = (WIDTH+2)'(W_MIN);

    typedef enum logic [1:0] {IDLE, SYN, POST} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic [N_SYN-1:0]        pre_q, pre_d;
    logic                    post_q, post_d;
    logic                    len_q, len_d;
    logic signed [WIDTH-1:0] r1_q, r1_d;
    logic signed [WIDTH-1:0] o1_q, o1_d;
    logic signed [WIDTH-1:0] r2_q [N_SYN];
    logic signed [WIDTH-1:0] r2_d [N_SYN];
    logic signed [WIDTH-1:0] w_q [N_SYN];
    logic signed [WIDTH-1:0] w_d [N_SYN];
    logic signed [WIDTH-1:0] rd_w_q, rd_w_d;
    logic                    done_q, done_d;
    logic                    ovr_q, ovr_d;

    logic signed [WIDTH-1:0]   r2_i, w_i, dp, dd, w_new;
    logic signed [2*WIDTH-1:0] r2_x, o1_x, prod, prod_f;
    logic signed [WIDTH+1:0]   sum;

    // Update datapath for the synapse currently addressed by idx_q.
    always_comb begin
        r2_i   = r2_q[idx_q];
        w_i    = w_q[idx_q];
        r2_x   = {{WIDTH{r2_i[WIDTH-1]}}, r2_i};
        o1_x   = {{WIDTH{o1_q[WIDTH-1]}}, o1_q};
        prod   = r2_x * o1_x;
        prod_f = prod >>> FRAC;
        dp     = '0;
        dd     = '0;
        if (post_q) begin
            if (MODE != 0) dp = $signed(prod_f[WIDTH-1:0]) >>> A3_PLUS;
            else           dp = r2_i >>> A3_PLUS;
        end
        if (pre_q[idx_q]) dd = r1_q >>> A2_MINUS;
        sum = (WIDTH+2)'(w_i) + (WIDTH+2)'(dp) - (WIDTH+2)'(dd);
        if (sum > W_MAX_X)      w_new = W_MAX_X[WIDTH-1:0];
        else if (sum < W_MIN_X) w_new = W_MIN_X[WIDTH-1:0];
        else                    w_new = sum[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pre_d   = pre_q;
        post_d  = post_q;
        len_d   = len_q;
        r1_d    = r1_q;
        o1_d    = o1_q;
        r2_d    = r2_q;
        w_d     = w_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;
        rd_w_d  = (int'(rd_addr) < N_SYN) ? w_q[rd_addr] : '0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    pre_d   = pre;
                    post_d  = post;
                    len_d   = learn_en;
                    idx_d   = '0;
                    state_d = SYN;
                end
            end
            SYN: begin
                if (tick) ovr_d = 1'b1;
                if (len_q) w_d[idx_q] = w_new;
                r2_d[idx_q] = pre_q[idx_q] ? ONE_W : r2_i - (r2_i >>> T_PLUS);
                if (idx_q == AW'(N_SYN - 1)) state_d = POST;
                else                         idx_d   = idx_q + 1'b1;
            end
            POST: begin
                if (tick) ovr_d = 1'b1;
                r1_d    = post_q ? ONE_W : r1_q - (r1_q >>> T_MINUS);
                o1_d    = post_q ? ONE_W : o1_q - (o1_q >>> T_Y);
                idx_d   = '0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pre_q   <= '0;
            post_q  <= 1'b0;
            len_q   <= 1'b0;
            r1_q    <= ONE_W;
            o1_q    <= ONE_W;
            for (int k = 0; k < N_SYN; k++) begin
                r2_q[k] <= ONE_W;
                w_q[k]  <= W_INIT_W;
            end
            rd_w_q  <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            post_q  <= post_d;
            len_q   <= len_d;
            r1_q    <= r1_d;
            o1_q    <= o1_d;
            r2_q    <= r2_d;
            w_q     <= w_d;
            rd_w_q  <= rd_w_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rd_w    = rd_w_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_bcm_stdp_array.sv
// Directed bench: default triplet array (a), clamped triplet (b) and clamped pair (c)
// driven with identical stimulus; expected weights computed by hand.
module tb_bcm_stdp_array;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] pre = '0;
    logic       post = 1'b0;
    logic       learn_en = 1'b0;
    logic [1:0] rd_addr = '0;

    logic [17:0] rd_a, rd_b, rd_c;
    logic busy_a, busy_b, busy_c, done_a, done_b, done_c, ovr_a, ovr_b, ovr_c;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bcm_stdp_array u_a (
        .clk(clk), .rst(rst), .tick(tick), .pre(pre), .post(post), .learn_en(learn_en),
        .rd_addr(rd_addr), .rd_w(rd_a), .busy(busy_a), .done(done_a), .overrun(ovr_a));

    bcm_stdp_array #(.W_MAX(32'h1800), .MODE(1)) u_b (
        .clk(clk), .rst(rst), .tick(tick), .pre(pre), .post(post), .learn_en(learn_en),
        .rd_addr(rd_addr), .rd_w(rd_b), .busy(busy_b), .done(done_b), .overrun(ovr_b));

    bcm_stdp_array #(.W_MAX(32'h1800), .MODE(0)) u_c (
        .clk(clk), .rst(rst), .tick(tick), .pre(pre), .post(post), .learn_en(learn_en),
        .rd_addr(rd_addr), .rd_w(rd_c), .busy(busy_c), .done(done_c), .overrun(ovr_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; tick = 1'b0; pre = '0; post = 1'b0; learn_en = 1'b0;
        clk1(); clk1();
        rst = 1'b1;
        clk1();
    endtask

    // Returns just after the accepting edge T.
    task automatic send_tick(input logic [3:0] p, input logic po, input logic le);
        tick = 1'b1; pre = p; post = po; learn_en = le;
        clk1();
        tick = 1'b0; pre = '0; post = 1'b0; learn_en = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        int k;
        k = 0;
        while (!done_a && k < 20) begin
            clk1();
            k++;
        end
        chk(tag, k, exp_cyc);
    endtask

    task automatic chk_w(input string tag, input logic [1:0] a,
                         input logic [17:0] ea, input logic [17:0] eb, input logic [17:0] ec);
        rd_addr = a;
        clk1();
        chk($sformatf("%s_a%0d", tag, a), rd_a, ea);
        chk($sformatf("%s_b%0d", tag, a), rd_b, eb);
        chk($sformatf("%s_c%0d", tag, a), rd_c, ec);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;

        // Reset state and tick timing with no spikes.
        do_reset();
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_ovr", ovr_a, 0);
        chk("rst_rdw", rd_a, 0);
        send_tick(4'b0000, 1'b0, 1'b1);
        for (int j = 1; j <= 6; j++) begin
            chk($sformatf("s1_busy_T%0d", j), busy_a, (j <= 5) ? 1 : 0);
            chk($sformatf("s1_done_T%0d", j), done_a, (j == 6) ? 1 : 0);
            clk1();
        end
        chk("s1_done_T7", done_a, 0);
        for (int a = 0; a < 4; a++) chk_w("s1_w0", 2'(a), 18'h0, 18'h0, 18'h0);
        // Decayed traces r2=0xF000, o1=r1=0xF800 show up in the next update.
        send_tick(4'b0001, 1'b1, 1'b1);
        wait_done("s1_lat", 5);
        chk_w("s1_w1", 2'd0, 18'h0C98, 18'h0C98, 18'h0D10);
        chk_w("s1_w1", 2'd1, 18'h0E88, 18'h0E88, 18'h0F00);
        chk_w("s1_w1", 2'd3, 18'h0E88, 18'h0E88, 18'h0F00);

        // Back-to-back post-only ticks, second issued in the done cycle.
        do_reset();
        send_tick(4'b0000, 1'b1, 1'b1);
        wait_done("s2_lat1", 5);
        send_tick(4'b0000, 1'b1, 1'b1);
        wait_done("s2_lat2", 5);
        chk("s2_ovr", ovr_a, 0);
        chk_w("s2_w", 2'd0, 18'h1F00, 18'h1800, 18'h1800);
        chk_w("s2_w", 2'd3, 18'h1F00, 18'h1800, 18'h1800);

        // Depression on one channel, learn disabled, then potentiation.
        do_reset();
        send_tick(4'b0100, 1'b0, 1'b1);
        wait_done("s3_lat1", 5);
        chk_w("s3_w1", 2'd2, 18'h3FE00, 18'h3FE00, 18'h3FE00);
        chk_w("s3_w1", 2'd0, 18'h0, 18'h0, 18'h0);
        send_tick(4'b0000, 1'b1, 1'b0);
        wait_done("s3_lat2", 5);
        chk_w("s3_w2", 2'd2, 18'h3FE00, 18'h3FE00, 18'h3FE00);
        chk_w("s3_w2", 2'd1, 18'h0, 18'h0, 18'h0);
        send_tick(4'b0000, 1'b1, 1'b1);
        wait_done("s3_lat3", 5);
        chk_w("s3_w3", 2'd2, 18'h0D00, 18'h0D00, 18'h0D00);
        chk_w("s3_w3", 2'd3, 18'h0E10, 18'h0E10, 18'h0E10);

        // Tick while busy is ignored and flags overrun.
        do_reset();
        send_tick(4'b0000, 1'b1, 1'b1);
        clk1();
        tick = 1'b1; pre = 4'b1111; post = 1'b0; learn_en = 1'b1;
        clk1();
        tick = 1'b0; pre = '0; post = 1'b0; learn_en = 1'b0;
        chk("s4_ovr", ovr_a, 1);
        wait_done("s4_lat", 3);
        nd = 0;
        repeat (6) begin
            clk1();
            nd += int'(done_a);
        end
        chk("s4_extra_done", nd, 0);
        chk_w("s4_w", 2'd0, 18'h1000, 18'h1000, 18'h1000);
        chk_w("s4_w", 2'd3, 18'h1000, 18'h1000, 18'h1000);
        chk("s4_ovr_sticky", ovr_a, 1);

        // Reset in the middle of a sequence.
        send_tick(4'b0000, 1'b1, 1'b1);
        clk1();
        tick = 1'b1;
        clk1();
        tick = 1'b0;
        clk1();
        rst = 1'b0;
        #1;
        chk("s5_busy", busy_a, 0);
        chk("s5_done", done_a, 0);
        chk("s5_ovr", ovr_a, 0);
        chk("s5_rdw", rd_a, 0);
        clk1();
        rst = 1'b1;
        nd = 0;
        repeat (8) begin
            clk1();
            nd += int'(done_a);
        end
        chk("s5_no_done", nd, 0);
        chk_w("s5_w", 2'd0, 18'h0, 18'h0, 18'h0);
        send_tick(4'b0000, 1'b0, 1'b0);
        wait_done("s5_fresh_lat", 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bcm_stdp_array.md
BCM_STDP_ARRAY -- requirements
Module: bcm_stdp_array

Interface
REQ-001 SHALL have parameters: N_SYN, default 4, number of presynaptic channels sharing one postsynaptic neuron.
REQ-002 SHALL have parameters: WIDTH, default 18, signed weight/trace width; FRAC, default 16, fraction bits (ONE = 1<<FRAC).
REQ-003 SHALL have parameters: T_PLUS 4, T_MINUS 5, T_Y 5, decay shifts for pre trace r2, post trace r1 and slow post trace o1.
REQ-004 SHALL have parameters: A3_PLUS 4 (potentiation shift), A2_MINUS 7 (depression shift).
REQ-005 SHALL have parameters: W_INIT 0, W_MAX +ONE, W_MIN -ONE, saturation bounds; MODE 1 (1 = triplet, 0 = pair).
REQ-006 Ports SHALL be:
 clk  in  1  rising-edge clock.
 rst  in  1  asynchronous, active-low reset.
 tick  in  1  one-cycle time-step strobe.
 pre  in  N_SYN  presynaptic spikes, sampled on accepted tick.
 post  in  1  postsynaptic spike, sampled on accepted tick.
 learn_en  in  1  weight-update enable, sampled on accepted tick.
 rd_addr  in  clog2(N_SYN) (min 1)  weight read address.
 rd_w  out  WIDTH signed  registered weight readout.
 busy  out  1  update sequence in progress.
 done  out  1  one-cycle completion pulse.
 overrun  out  1  sticky: tick arrived while busy.

Function
REQ-007 State machine SHALL have states IDLE, SYN, POST; tick accepted only in IDLE.
REQ-008 Tick accepted at edge T SHALL latch pre, post, learn_en into pre_q, post_q, len_q, enter SYN with index i=0; busy=1 from T+1.
REQ-009 In SYN, one synapse per cycle: synapse i SHALL commit at edge T+1+i; after i=N_SYN-1 go to POST.
REQ-010 Synapse update SHALL use trace values from before this tick's decay (r1, o1, r2[i] as stored at T).
REQ-011 Potentiation: if post_q, dp = MODE ? ((r2[i]*o1) >> FRAC) >>> A3_PLUS : r2[i] >>> A3_PLUS; else dp=0; product in 2*WIDTH bits.
REQ-012 Depression: if pre_q[i], dd = r1 >>> A2_MINUS; else dd=0.
REQ-013 If len_q, w[i] SHALL become clamp(w[i] + dp - dd, W_MIN, W_MAX) computed in WIDTH+2 bits; if !len_q, w[i] unchanged.
REQ-014 Same cycle: r2[i] SHALL become ONE if pre_q[i], else r2[i] - (r2[i] >>> T_PLUS).
REQ-015 POST (edge T+N_SYN+1): r1 = post_q ? ONE : r1 - (r1>>>T_MINUS); o1 = post_q ? ONE : o1 - (o1>>>T_Y); return to IDLE.
REQ-016 done SHALL be high for exactly the cycle after POST (cycle T+N_SYN+2) with busy=0 in that cycle; a new tick is acceptable in that cycle.
REQ-017 Tick while busy SHALL be ignored (no latch, no extra done) and set overrun=1 until reset.
REQ-018 rd_w SHALL equal w[rd_addr] one cycle after the address, reading the value stored before any write at the same edge; rd_addr >= N_SYN returns 0.
REQ-019 Traces SHALL remain within [0, ONE]; decay of 0 stays 0.

Reset
REQ-020 rst low SHALL immediately (asynchronously) force: all w = W_INIT, r1 = o1 = all r2 = ONE, rd_w=0, busy=0, done=0, overrun=0, state IDLE, i=0, latched spikes 0.
REQ-021 Reset mid-sequence SHALL abort it; no done pulse follows; the first tick after rst release starts a fresh sequence.

Verification (defaults, N_SYN=4)
REQ-022 Reset, tick with pre=0, post=0 -> w all 0, every r2=0xF000, r1=o1=0xF800; busy for T+1..T+5, done at T+6.
REQ-023 Reset, tick post=1, learn_en=1 -> every w = 0x1000 (triplet: (0x10000*0x10000>>16)>>>4); r1=o1=0x10000.
REQ-024 Reset, tick pre=4'b0100, learn_en=1 -> w[2] = -0x200 (0x3FE00), others 0; r2[2]=0x10000, others 0xF000.
REQ-025 W_MAX=0x1800, two consecutive post-only ticks -> w = 0x1000 then 0x1800 (0x1F00 clamped); MODE=0 gives the same values.
REQ-026 Tick again at T+2 while busy -> ignored, overrun=1, single done at T+6; rst low at T+3 -> outputs reset immediately, no done.
